data_mem_ctl: RTL and testbench
===============================

Name: data_mem_ctl

Overview:
- Parametrised multi-cycle data memory for the 8-bit CPU; generalises the single-latency 256x8 data memory.
- Provides configurable data/address width and separate read and write latencies.
- Adds a hardware zero-clear sweep after reset, request latching, and a one-cycle release state so the stalled CPU advances cleanly.
- Sits between the control unit/ALU (address, write_data, read/write strobes) and the register-file write-back mux; busy_wait stalls the PC and the register file.

Parameters:
- ADDR_W, 8: address width; depth = 2**ADDR_W words.
- DATA_W, 8: word width.
- RD_LAT, 10: read latency in clk cycles, legal range 1..255.
- WR_LAT, 10: write latency in clk cycles, legal range 1..255.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- read  in  1  read request level.
- write  in  1  write request level.
- address  in  ADDR_W  word address.
- write_data  in  DATA_W  store data.
- read_data  out  DATA_W  load result, held until the next completed read.
- busy_wait  out  1  stall to CPU.
- err  out  1  one-cycle flag: illegal request (read and write both high).

Behaviour:
- States: CLEAR, IDLE, RD_WAIT, WR_WAIT, DONE. State encoding lives in the package.
- Reset (rst=0, any time, including mid-access):
  - state=CLEAR, clear pointer=0, latency counter=0, read_data=0, err=0.
  - Any in-flight access is abandoned; the array is not written.
- CLEAR:
  - One word per cycle: mem[ptr]<=0, ptr++.
  - After the edge that writes word depth-1, go to IDLE. Sweep takes exactly 2**ADDR_W cycles.
  - busy_wait=1 throughout; requests are ignored, not queued.
- IDLE:
  - busy_wait = read XOR write (combinational), so the CPU stalls in the same cycle it issues the request.
  - Posedge with read=1, write=0: latch address; counter=RD_LAT-1; go to RD_WAIT.
  - Posedge with write=1, read=0: latch address and write_data; counter=WR_LAT-1; go to WR_WAIT.
  - read=1 and write=1: no access, busy_wait=0, err=1 for that posedge only (registered, cleared next cycle); stay in IDLE.
- RD_WAIT / WR_WAIT:
  - busy_wait=1.
  - Counter decrements each posedge. On the posedge where counter==0, perform the access using the latched values and go to DONE.
  - Read: read_data<=mem[addr_q]. Write: mem[addr_q]<=data_q.
  - Request inputs and address changes during the wait are ignored.
  - Completion occurs exactly LAT posedges after the accepting posedge.
- DONE:
  - busy_wait=0 for exactly one cycle; requests ignored; next posedge goes to IDLE.
  - The CPU advances on that same edge, so the still-high old strobe is never re-accepted.
- Back-to-back accesses: a new request is accepted no earlier than 2 cycles after completion (DONE, then IDLE).
- read_data changes only on read completion or reset. Writes never alter read_data.
- Address wrap: addresses are ADDR_W bits and index the full array; there is no out-of-range case.
- Read-after-write to the same address returns the new value, because the write completes before the read is accepted.

Decomposition:
- Shared package data_mem_pkg holds:
  - the state enum/localparams (CLEAR, IDLE, RD_WAIT, WR_WAIT, DONE);
  - the latency counter width constant LAT_W=8.
- One natural sub-module: mem_array_1rw, a synchronous single-port DEPTHxDATA_W array with registered read and no reset.
- The controller FSM, counter and clear sweep stay in data_mem_ctl.

Test Plan (ADDR_W=4, DATA_W=8, RD_LAT=3, WR_LAT=2 unless noted):
- Release rst after 2 cycles -> busy_wait=1 for exactly 16 cycles; then a read of address 9 returns 0x00.
- write=1, address=5, write_data=0x11 -> busy_wait high in the request cycle; mem[5]=0x11 two posedges after acceptance; busy_wait=0 for the DONE cycle.
- After that, read=1, address=5 -> read_data=0x11 three posedges after acceptance; read_data unchanged by a subsequent write of 0x22 to address 5.
- Strobe held high through DONE with the PC advancing each release -> each instruction performs exactly one access (count completions = count of requests).
- read=1 and write=1 together -> err pulses 1 cycle; busy_wait stays 0; memory and read_data unchanged.
- rst=0 midway through RD_WAIT -> read_data=0 immediately; full 16-cycle CLEAR sweep follows; a later read of any address returns 0x00.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the multi-cycle data memory controller.
package data_mem_pkg;

  localparam int unsigned LAT_W = 8;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StRdWait,
    StWrWait,
    StDone
  } state_e;

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port synchronous RAM, registered read, no reset on storage or read register.
module mem_array_1rw #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctl.sv
// Multi-cycle data memory controller: post-reset zero sweep, latched requests,
// separate read/write latencies and a one-cycle release state.
module data_mem_ctl
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 10,
  parameter int unsigned WR_LAT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy_wait,
  output logic              err
);

  localparam logic [LAT_W-1:0] RdCnt = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WrCnt = LAT_W'(WR_LAT - 1);

  state_e             state_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [LAT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               err_q;
  logic               rd_valid_q;

  logic               access_fire;
  logic               arr_en;
  logic               arr_we;
  logic [ADDR_W-1:0]  arr_addr;
  logic [DATA_W-1:0]  arr_wdata;
  logic [DATA_W-1:0]  arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) state_q <= StIdle;
        end
        StIdle: begin
          if (read && write) begin
            err_q <= 1'b1;
          end else if (read) begin
            addr_q  <= address;
            cnt_q   <= RdCnt;
            state_q <= StRdWait;
          end else if (write) begin
            addr_q  <= address;
            data_q  <= write_data;
            cnt_q   <= WrCnt;
            state_q <= StWrWait;
          end
        end
        StRdWait: begin
          if (cnt_q == '0) begin
            rd_valid_q <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrWait: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StClear;
      endcase
    end
  end

  // The array is only touched by the sweep and on the completing edge of an access.
  always_comb begin
    access_fire = ((state_q == StRdWait) || (state_q == StWrWait)) && (cnt_q == '0);
    arr_en      = (state_q == StClear) || access_fire;
    arr_we      = (state_q == StClear) || (state_q == StWrWait);
    arr_addr    = (state_q == StClear) ? ptr_q : addr_q;
    arr_wdata   = (state_q == StClear) ? '0 : data_q;
  end

  always_comb begin
    busy_wait = 1'b1;
    unique case (state_q)
      StIdle:  busy_wait = read ^ write;
      StDone:  busy_wait = 1'b0;
      default: busy_wait = 1'b1;
    endcase
  end

  // The array read register has no reset, so mask it until the first completed read.
  assign read_data = rd_valid_q ? arr_rdata : '0;
  assign err       = err_q;

  mem_array_1rw #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctl.sv
// Directed bench for data_mem_ctl with a read-data scoreboard and a small memory model.
module tb_data_mem_ctl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned WR_LAT = 2;
  localparam int unsigned Depth  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              busy_wait;
  logic              err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] model [Depth];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_rd;

  data_mem_ctl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy_wait  (busy_wait),
    .err        (err)
  );

  always #5 clk = ~clk;

  // A released stall while a single strobe is high can only be the DONE cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && (read ^ write) && busy_wait === 1'b0) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy_wait === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, Depth);
  endtask

  // Issue one access from IDLE; on return the controller is back in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit drop);
    int n = 0;
    logic [DATA_W-1:0] e;
    read = rd; write = wr; address = a; write_data = d;
    #1;
    check("stall_in_req_cycle", busy_wait, 1);
    if (rd) exp_q.push_back(model[a]);
    tick();
    // Disturb inputs during the wait; the latched request must win.
    address = ~a; write_data = ~d;
    check("rdata_held_in_wait", read_data, last_rd);
    do begin
      tick();
      n++;
    end while (busy_wait === 1'b1 && n < 50);
    check(rd ? "read_latency" : "write_latency", n, rd ? RD_LAT : WR_LAT);
    check("done_release", busy_wait, 0);
    if (rd) begin
      e = exp_q.pop_front();
      check("read_data", read_data, e);
      last_rd = e;
    end else begin
      model[a] = d;
      check("rdata_after_write", read_data, last_rd);
    end
    tick();
    if (drop) begin
      read = 1'b0; write = 1'b0;
    end
    #1;
    check("idle_after_done", busy_wait, drop ? 0 : 1);
  endtask

  initial begin
    int base;
    rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    last_rd = '0;
    for (int i = 0; i < Depth; i++) model[i] = '0;

    tick();
    check("rst_busy", busy_wait, 1);
    check("rst_rdata", read_data, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b1;
    wait_clear("clear_len");

    access(1, 0, 4'd9, 8'h00, 1);
    access(0, 1, 4'd5, 8'h11, 1);
    access(1, 0, 4'd5, 8'h00, 1);
    access(0, 1, 4'd5, 8'h22, 1);
    access(0, 1, 4'd15, 8'hA5, 1);
    access(1, 0, 4'd15, 8'h00, 1);

    // Strobe held high through DONE across three instructions.
    base = done_cnt;
    access(1, 0, 4'd5, 8'h00, 0);
    access(1, 0, 4'd15, 8'h00, 0);
    access(1, 0, 4'd9, 8'h00, 1);
    check("held_completions", done_cnt - base, 3);
    repeat (3) tick();
    check("held_no_extra", done_cnt - base, 3);

    // Illegal simultaneous request.
    read = 1'b1; write = 1'b1; address = 4'd5; write_data = 8'h77;
    #1;
    check("illegal_busy", busy_wait, 0);
    check("illegal_err_pre", err, 0);
    tick();
    read = 1'b0; write = 1'b0;
    #1;
    check("illegal_err", err, 1);
    check("illegal_busy_after", busy_wait, 0);
    check("illegal_rdata", read_data, last_rd);
    tick();
    check("illegal_err_clear", err, 0);
    access(1, 0, 4'd5, 8'h00, 1);

    // Reset in the middle of RD_WAIT.
    read = 1'b1; address = 4'd15;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_rdata", read_data, 0);
    check("midrst_busy", busy_wait, 1);
    read = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    last_rd = '0;
    for (int i = 0; i < Depth; i++) model[i] = '0;
    wait_clear("clear_len_after_midrst");
    access(1, 0, 4'd15, 8'h00, 1);
    access(1, 0, 4'd5, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
